// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: walks from the round-10 key back to round 0, one round per cycle.
// Latency: start accepted in cycle 0 -> round key 10 valid in cycle 1 (cycle 11 with INV_KEY_FWD_EN), one key per cycle after.
// Backpressure: rk_valid/rk_ready; while rk_ready=0 rk_out/rk_round hold and the schedule stalls.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, key_in   begin a schedule from key_in (round-10 key, or cipher key with INV_KEY_FWD_EN)
//   rk_out/rk_round round key stream (rounds 10..0), qualified by rk_valid, accepted with rk_ready
//   busy, done      busy from cycle after start until last handshake; done pulses after round 0 is taken
//
// Optional build macro: INV_KEY_FWD_EN -- key_in is the cipher key; a forward pass (FWD state,
// ten key_exp steps) derives the round-10 key before emission starts.
module inv_key_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("inv_key_sched: NUM_ROUNDS must be 10 (AES-128)");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers and SBox (multiplicative inverse as x^254, then affine map)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gf_mul(x, x);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    // x^254 = x^-1 for x != 0, and 0 maps to 0 as the SBox requires
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // rcon(r) is the constant that links round r-1 and round r
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

`ifdef INV_KEY_FWD_EN
  // Forward key_exp step: derives round r key from round r-1 key
  function automatic logic [0:127] key_exp(input logic [0:127] k, input logic [3:0] round_number);
    logic [0:31] w0, w1, w2, w3, rot, g;
    w0  = k[0:31];
    w1  = k[32:63];
    w2  = k[64:95];
    w3  = k[96:127];
    rot = {w3[8:31], w3[0:7]};
    g   = {aes_sbox(rot[0:7]) ^ rcon(round_number), aes_sbox(rot[8:15]),
           aes_sbox(rot[16:23]), aes_sbox(rot[24:31])};
    w0  = w0 ^ g;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
`ifdef INV_KEY_FWD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FWD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1} state_t;
`endif

  state_t       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // ---------------------------------------------------------------------------
  // Inverse step: previous round key from the current one (four SBoxes)
  // ---------------------------------------------------------------------------
  logic [0:31]  iw0, iw1, iw2, iw3, irot, ig;
  logic [0:127] inv_key;

  always_comb begin
    iw3     = key_q[96:127] ^ key_q[64:95];
    iw2     = key_q[64:95]  ^ key_q[32:63];
    iw1     = key_q[32:63]  ^ key_q[0:31];
    irot    = {iw3[8:31], iw3[0:7]};
    ig      = {aes_sbox(irot[0:7]) ^ rcon(cnt_q), aes_sbox(irot[8:15]),
               aes_sbox(irot[16:23]), aes_sbox(irot[24:31])};
    iw0     = key_q[0:31] ^ ig;
    inv_key = {iw0, iw1, iw2, iw3};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle still counts as the tail of the previous schedule,
        // so a start coinciding with done is dropped.
        if (start && !done_q) begin
          key_d  = key_in;
          busy_d = 1'b1;
`ifdef INV_KEY_FWD_EN
          cnt_d   = 4'd1;
          state_d = FWD;
`else
          cnt_d      = LAST_RND;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
`endif
        end
      end
`ifdef INV_KEY_FWD_EN
      FWD: begin
        key_d = key_exp(key_q, cnt_q);
        if (cnt_q == LAST_RND) begin
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      EMIT: begin
        if (rk_ready) begin
          if (cnt_q != 4'd0) begin
            key_d = inv_key;
            cnt_d = cnt_q - 4'd1;
          end else begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      cnt_q      <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_out   = key_q;
  assign rk_round = cnt_q;
  assign rk_valid = rk_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// Testbench for inv_key_sched: directed and randomized schedules checked against a
// word-array AES key expansion model built from log/antilog GF(2^8) tables.
module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

`ifdef INV_KEY_FWD_EN
  localparam int           FIRST_CYC = 11;
  localparam logic [127:0] SPEC_IN   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  localparam int           FIRST_CYC = 1;
  localparam logic [127:0] SPEC_IN   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

  inv_key_sched #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [7:0]   alog [255];
  int           logt [256];
  logic [7:0]   rc [11];
  logic [31:0]  w [44];
  logic [127:0] exp_rk [11];
  logic [127:0] obs_rk [11];
  int           last_cyc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  task automatic build_tables();
    logic [7:0] e, inv, s, c;
    c = 8'h63;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = e;
      logt[e] = i;
      e = e ^ xt(e);   // multiply by generator 3
    end
    sb[0] = 8'h63;
    for (int x = 1; x < 256; x++) begin
      inv = alog[(255 - logt[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
      sb[x] = s;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = xt(rc[i-1]);
  endtask

  function automatic logic [31:0] tmp_word(input int i, input logic [31:0] prev);
    logic [31:0] r;
    if (i % 4 != 0) return prev;
    r = {prev[23:0], prev[31:24]};
    return {sb[r[31:24]] ^ rc[i/4], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
  endfunction

  task automatic build_model(input logic [127:0] k);
`ifdef INV_KEY_FWD_EN
    for (int j = 0; j < 4; j++) w[j] = k[127 - 32*j -: 32];
    for (int i = 4; i < 44; i++) w[i] = w[i-4] ^ tmp_word(i, w[i-1]);
`else
    for (int j = 0; j < 4; j++) w[40 + j] = k[127 - 32*j -: 32];
    for (int i = 43; i >= 4; i--) w[i-4] = w[i] ^ tmp_word(i, w[i-1]);
`endif
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one schedule. Caller is at a negedge; start is raised immediately.
  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
  // gate: throw start pulses during the schedule and on the done cycle.
  task automatic run_sched(input logic [127:0] k, input int mode, input bit gate);
    int cyc, nxt, first_cyc, pidx;
    bit stalled, rdy;
    logic [127:0] held_out;
    logic [3:0]   held_rnd;
    build_model(k);
    start = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc = 1; nxt = 10; first_cyc = -1; pidx = 0; stalled = 1'b0;
    held_out = '0; held_rnd = '0;
    while (nxt >= 0 && cyc < 400) begin
      if (rk_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk("first_valid_cycle", first_cyc, FIRST_CYC);
        end
        if (stalled) begin
          chk("stall_hold_out", rk_out, held_out);
          chk("stall_hold_round", rk_round, held_rnd);
        end
        chk("rk_round", rk_round, nxt);
        chk("rk_out", rk_out, exp_rk[nxt]);
      end
      chk("busy_during", busy, 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pidx % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rk_ready = rdy;
      start = gate && ($urandom_range(0, 3) == 0);
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (rk_valid && rdy) begin
        obs_rk[nxt] = rk_out;
        last_cyc = cyc;
        nxt--;
        stalled = 1'b0;
      end else if (rk_valid) begin
        stalled = 1'b1;
        held_out = rk_out;
        held_rnd = rk_round;
      end
      @(negedge clk);
      cyc++;
      pidx++;
    end
    if (cyc >= 400) chk("sched_timeout_keys_left", nxt + 1, 0);
    chk("done_pulse", done, 1);
    chk("valid_after_last", rk_valid, 0);
    chk("busy_after_last", busy, 0);
    start = gate;   // start on the done cycle must be ignored
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("no_restart_on_done", rk_valid, 0);
    chk("idle_not_busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    build_tables();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", rk_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_round", rk_round, 0);
    chk("reset_out", rk_out, 0);

    // Streaming with the FIPS-197 example key
    run_sched(SPEC_IN, 0, 1'b0);
    chk("spec_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("spec_rk9",  obs_rk[9],  128'hac7766f319fadc2128d12941575c006e);
    chk("spec_rk1",  obs_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("spec_rk0",  obs_rk[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("spec_last_key_cycle", last_cyc, FIRST_CYC + 10);

    // Backpressure 1,0,0 with start gating; begins the cycle right after done
    run_sched(SPEC_IN, 1, 1'b1);
    chk("bp_rk0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Mid-schedule reset at round 5
    start = 1'b1; key_in = SPEC_IN; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (rk_valid && rk_round == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("reset_point_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", rk_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_round", rk_round, 0);
    @(negedge clk);
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", rk_valid, 0);
    run_sched(SPEC_IN, 0, 1'b0);

    // Randomized keys, ready patterns and start gating
    for (int n = 0; n < 6; n++) begin
      run_sched({$urandom(), $urandom(), $urandom(), $urandom()},
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
